dmg_timer: RTL and testbench
============================

DMG_TIMER -- requirements
Module: dmg_timer

Interface
REQ-001 SHALL have parameter RELOAD_DELAY, default 4, meaning clk cycles TIMA reads 0x00 after overflow before TMA reload.
REQ-002 SHALL have port clk, input, 1, system T-cycle clock, the same clock dmg_main runs on.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port reg_addr, input, 2, register select: 0=DIV (0xff04), 1=TIMA (0xff05), 2=TMA (0xff06), 3=TAC (0xff07).
REQ-005 SHALL have port reg_write, input, 1, write strobe for the register at reg_addr, sampled each clk edge.
REQ-006 SHALL have port d_wr, input, 8, write data.
REQ-007 SHALL have port reg_d_rd, output, 8, combinational read data for reg_addr.
REQ-008 SHALL have port irq_timer, output, 1, timer interrupt request, feeding irq[2] of dmg_main.

Function
REQ-009 SHALL keep a 16-bit free-running counter div_ctr that increments by 1 every clk and wraps 0xffff->0x0000.
REQ-010 Reads SHALL return: DIV = div_ctr[15:8]; TIMA; TMA; TAC = {5'b11111, tac[2:0]}.
REQ-011 A DIV write (any data) SHALL clear div_ctr to 0x0000 on that edge, instead of incrementing it.
REQ-012 tick = tac[2] & div_ctr[sel], with sel by tac[1:0]: 00->bit 9, 01->bit 3, 10->bit 5, 11->bit 7.
REQ-013 SHALL register tick as tick_q; a falling edge (tick_q=1, tick=0) SHALL increment TIMA on the next edge.
REQ-014 Falling edges caused by a DIV write or a TAC write SHALL also increment TIMA, as on DMG hardware.
REQ-015 SHALL implement the state machine RUN -> OVF -> RELOAD -> RUN.
REQ-016 RUN: TIMA=0xff plus increment SHALL give TIMA=0x00 and go to OVF with delay counter = RELOAD_DELAY-1.
REQ-017 OVF: TIMA SHALL read 0x00, plus any increments, while the delay counter counts to 0, then go to RELOAD.
REQ-018 A TIMA write in OVF SHALL load d_wr, cancel the reload and interrupt, and return to RUN.
REQ-019 RELOAD (one clk): TIMA SHALL be loaded with TMA and irq_timer asserted, then go to RUN.
REQ-020 In RELOAD, a TIMA write SHALL be ignored.
REQ-021 In RELOAD, a TMA write SHALL update TMA, and the new value SHALL be loaded into TIMA.
REQ-022 irq_timer SHALL be high for exactly 4 clk starting on the edge after RELOAD, so that at least one cpu_ce sample (every 4th clk) catches it.
REQ-023 irq_timer SHALL retrigger (restart its 4-clk count) if another RELOAD occurs while it is high.
REQ-024 A TIMA write in RUN SHALL take priority over a same-cycle increment.
REQ-025 A TMA write in RUN or OVF SHALL not change TIMA.
REQ-026 Writes to TAC SHALL store d_wr[2:0] only.
REQ-027 tac[2]=0 SHALL hold TIMA, except for the edge case in REQ-014; div_ctr SHALL always run.

Reset
REQ-028 On rst low, SHALL asynchronously clear div_ctr, TIMA, TMA, tac, tick_q, the delay counter and the irq counter, enter RUN, and drive irq_timer=0.
REQ-029 After reset, reads SHALL give DIV=0x00, TIMA=0x00, TMA=0x00, TAC=0xf8.
REQ-030 Reset asserted in OVF or RELOAD SHALL abort the reload, with no irq_timer pulse after release.

Verification
REQ-031 Reset release, TAC=0x05, TIMA=0xfe, TMA=0x40, 64 clk -> TIMA 0xfe->0xff->0x00, reads 0x00 for 4 clk, then 0x40; irq_timer high exactly 4 clk.
REQ-032 Same setup, TIMA write 0x77 during OVF -> TIMA=0x77, no reload to 0x40, irq_timer stays 0.
REQ-033 TMA write 0x99 in the RELOAD cycle -> TIMA=0x99; a same-cycle TIMA write of 0x11 is ignored; irq_timer pulses.
REQ-034 TAC=0x05, wait until div_ctr[3]=1, write DIV -> div_ctr=0x0000 and TIMA +1; DIV reads 0x00, then 0x01 after 256 clk.
REQ-035 TAC=0x04, TIMA=0x00, 1024 clk -> TIMA=0x01; TAC=0x00, 4096 clk -> TIMA unchanged; div_ctr wraps at 65536 clk.
REQ-036 Reset pulsed two clk into OVF -> all registers at reset values; irq_timer never asserted.

Source files
------------

// File: rtl/dmg_timer.sv
// DMG timer block: DIV/TIMA/TMA/TAC registers, falling-edge TIMA clocking,
// delayed TMA reload after overflow and a stretched timer interrupt.
module dmg_timer #(
    parameter int unsigned RELOAD_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] reg_addr,
    input  logic       reg_write,
    input  logic [7:0] d_wr,
    output logic [7:0] reg_d_rd,
    output logic       irq_timer
);

    localparam int unsigned DLY_W   = (RELOAD_DELAY > 2) ? $clog2(RELOAD_DELAY) : 1;
    localparam int unsigned IRQ_LEN = 4;
    localparam int unsigned IRQ_W   = 3;

    localparam logic [1:0] A_DIV  = 2'd0;
    localparam logic [1:0] A_TIMA = 2'd1;
    localparam logic [1:0] A_TMA  = 2'd2;
    localparam logic [1:0] A_TAC  = 2'd3;

    typedef enum logic [1:0] {RUN, OVF, RELOAD} state_t;

    state_t             state_q, state_d;
    logic [15:0]        div_q, div_d;
    logic [7:0]         tima_q, tima_d;
    logic [7:0]         tma_q, tma_d;
    logic [2:0]         tac_q, tac_d;
    logic               tick_q, tick;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [IRQ_W-1:0]   irq_cnt_q, irq_cnt_d;
    logic               inc;
    logic               wr_div, wr_tima, wr_tma, wr_tac;

    assign wr_div  = reg_write && (reg_addr == A_DIV);
    assign wr_tima = reg_write && (reg_addr == A_TIMA);
    assign wr_tma  = reg_write && (reg_addr == A_TMA);
    assign wr_tac  = reg_write && (reg_addr == A_TAC);

    // Selected divider tap; DIV/TAC writes that drop it also count as a falling edge.
    always_comb begin
        tick = 1'b0;
        case (tac_q[1:0])
            2'b00:   tick = div_q[9];
            2'b01:   tick = div_q[3];
            2'b10:   tick = div_q[5];
            default: tick = div_q[7];
        endcase
        tick = tick & tac_q[2];
    end

    assign inc = tick_q & ~tick;

    always_comb begin
        state_d   = state_q;
        div_d     = wr_div ? 16'h0000 : div_q + 16'd1;
        tima_d    = tima_q;
        tma_d     = wr_tma ? d_wr : tma_q;
        tac_d     = wr_tac ? d_wr[2:0] : tac_q;
        dly_d     = dly_q;
        irq_cnt_d = (irq_cnt_q != '0) ? irq_cnt_q - IRQ_W'(1) : '0;
        case (state_q)
            RUN: begin
                if (wr_tima) begin
                    tima_d = d_wr;
                end else if (inc) begin
                    if (tima_q == 8'hff) begin
                        tima_d = 8'h00;
                        if (RELOAD_DELAY > 1) begin
                            state_d = OVF;
                            dly_d   = DLY_W'(RELOAD_DELAY - 1);
                        end else begin
                            state_d = RELOAD;
                        end
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            OVF: begin
                // A CPU write here wins over the pending reload and its interrupt.
                if (wr_tima) begin
                    tima_d  = d_wr;
                    state_d = RUN;
                    dly_d   = '0;
                end else begin
                    if (inc) tima_d = tima_q + 8'd1;
                    if (dly_q <= DLY_W'(1)) begin
                        state_d = RELOAD;
                        dly_d   = '0;
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
            end
            RELOAD: begin
                tima_d    = tma_d;
                irq_cnt_d = IRQ_W'(IRQ_LEN);
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            div_q     <= '0;
            tima_q    <= '0;
            tma_q     <= '0;
            tac_q     <= '0;
            tick_q    <= 1'b0;
            dly_q     <= '0;
            irq_cnt_q <= '0;
            irq_timer <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            tick_q    <= tick;
            dly_q     <= dly_d;
            irq_cnt_q <= irq_cnt_d;
            irq_timer <= (irq_cnt_d != '0);
        end
    end

    always_comb begin
        reg_d_rd = 8'h00;
        case (reg_addr)
            A_DIV:   reg_d_rd = div_q[15:8];
            A_TIMA:  reg_d_rd = tima_q;
            A_TMA:   reg_d_rd = tma_q;
            default: reg_d_rd = {5'b11111, tac_q};
        endcase
    end

endmodule

// File: tb/tb_dmg_timer.sv
// Bench for dmg_timer: vector table, directed corner sequences and random
// traffic, all checked each cycle against an edge-scheduled reference model.
module tb_dmg_timer;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] reg_addr;
    logic       reg_write;
    logic [7:0] d_wr;
    logic [7:0] reg_d_rd;
    logic       irq_timer;

    always #5 clk = ~clk;

    dmg_timer #(.RELOAD_DELAY(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_addr  (reg_addr),
        .reg_write (reg_write),
        .d_wr      (d_wr),
        .reg_d_rd  (reg_d_rd),
        .irq_timer (irq_timer)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: plain integers, reload and interrupt tracked as absolute edge numbers.
    int m_div, m_tima, m_tma, m_tac, m_tickq, m_pend, m_reload_at, m_irq_at, m_n;
    logic [7:0] last_rd;
    logic       last_irq;

    typedef struct {
        logic [1:0] a;
        logic       w;
        logic [7:0] d;
        logic [7:0] rd;
        logic       irq;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_read(input int a);
        case (a)
            0:       return (m_div >> 8) & 255;
            1:       return m_tima;
            2:       return m_tma;
            default: return 248 | m_tac;
        endcase
    endfunction

    function automatic int m_irq();
        return ((m_n - m_irq_at) >= 0 && (m_n - m_irq_at) <= 3) ? 1 : 0;
    endfunction

    task automatic m_reset();
        m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_tickq = 0;
        m_pend = 0; m_reload_at = 0; m_irq_at = -100; m_n = 0;
    endtask

    task automatic m_edge(input int a, input int w, input int d);
        int sel, tick, inc, ntma;
        m_n++;
        case (m_tac & 3)
            0:       sel = 9;
            1:       sel = 3;
            2:       sel = 5;
            default: sel = 7;
        endcase
        tick = ((m_tac >> 2) & 1) & ((m_div >> sel) & 1);
        inc  = (m_tickq == 1 && tick == 0) ? 1 : 0;
        ntma = (w != 0 && a == 2) ? d : m_tma;
        if (m_pend != 0 && m_n == m_reload_at) begin
            m_tima = ntma;
            m_pend = 0;
            m_irq_at = m_n;
        end else if (m_pend != 0) begin
            if (w != 0 && a == 1) begin
                m_tima = d;
                m_pend = 0;
            end else if (inc != 0) begin
                m_tima = (m_tima + 1) & 255;
            end
        end else begin
            if (w != 0 && a == 1) m_tima = d;
            else if (inc != 0) begin
                if (m_tima == 255) begin
                    m_tima = 0;
                    m_pend = 1;
                    m_reload_at = m_n + RD;
                end else begin
                    m_tima = m_tima + 1;
                end
            end
        end
        m_tma   = ntma;
        m_tickq = tick;
        m_div   = (w != 0 && a == 0) ? 0 : (m_div + 1) & 65535;
        if (w != 0 && a == 3) m_tac = d & 7;
    endtask

    // One clock: drive, sample at negedge against the model, then advance both.
    task automatic step(input logic [1:0] a, input logic w, input logic [7:0] d);
        reg_addr = a; reg_write = w; d_wr = d;
        @(negedge clk);
        last_rd  = reg_d_rd;
        last_irq = irq_timer;
        chk("rd", 32'(last_rd), 32'(m_read(int'(a))));
        chk("irq", 32'(last_irq), 32'(m_irq()));
        @(posedge clk);
        m_edge(int'(a), int'(w), int'(d));
        #1;
    endtask

    task automatic wait_tima0();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step(2'd1, 1'b0, 8'h00);
            if (last_rd == 8'h00) ok = 1;
        end
        chk("wait_ovf", 32'(ok), 32'd1);
    endtask

    initial begin
        int zr, after, irqc;
        bit seenff, done, seen40;
        logic [1:0] ra;
        logic       rw;
        logic [7:0] rdat;

        rst = 1'b0; reg_addr = 2'd0; reg_write = 1'b0; d_wr = 8'h00;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        tbl[0] = '{2'd0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{2'd1, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{2'd2, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{2'd3, 1'b0, 8'h00, 8'hf8, 1'b0};
        tbl[4] = '{2'd2, 1'b1, 8'h40, 8'h00, 1'b0};
        tbl[5] = '{2'd2, 1'b0, 8'h00, 8'h40, 1'b0};
        tbl[6] = '{2'd3, 1'b1, 8'hfd, 8'hf8, 1'b0};
        tbl[7] = '{2'd3, 1'b0, 8'h00, 8'hfd, 1'b0};
        tbl[8] = '{2'd1, 1'b1, 8'hfe, 8'h00, 1'b0};
        tbl[9] = '{2'd1, 1'b0, 8'h00, 8'hfe, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].a, tbl[i].w, tbl[i].d);
            chk("tbl_rd", 32'(last_rd), 32'(tbl[i].rd));
            chk("tbl_irq", 32'(last_irq), 32'(tbl[i].irq));
        end

        // Overflow, 4 cycles of 0x00, reload to TMA, 4-cycle interrupt.
        zr = 0; after = -1; irqc = 0; seenff = 0; done = 0;
        for (int i = 0; i < 64; i++) begin
            step(2'd1, 1'b0, 8'h00);
            if (last_irq) irqc++;
            if (!done) begin
                if (last_rd == 8'h00) zr++;
                else if (zr > 0) begin after = int'(last_rd); done = 1; end
                else if (last_rd == 8'hff) seenff = 1;
            end
        end
        chk("ovf_seen_ff", 32'(seenff), 32'd1);
        chk("ovf_zero_run", 32'(zr), 32'd4);
        chk("ovf_reload_val", 32'(after), 32'h40);
        chk("ovf_irq_len", 32'(irqc), 32'd4);

        // TIMA write during OVF cancels reload and interrupt.
        step(2'd1, 1'b1, 8'hfe);
        wait_tima0();
        step(2'd1, 1'b1, 8'h77);
        irqc = 0; seen40 = 0;
        for (int i = 0; i < 12; i++) begin
            step(2'd1, 1'b0, 8'h00);
            if (i == 0) chk("ovf_cancel_val", 32'(last_rd), 32'h77);
            if (last_irq) irqc++;
            if (last_rd == 8'h40) seen40 = 1;
        end
        chk("ovf_cancel_irq", 32'(irqc), 32'd0);
        chk("ovf_cancel_noreload", 32'(seen40), 32'd0);

        // TIMA write in the RELOAD cycle is ignored.
        step(2'd1, 1'b1, 8'hfe);
        wait_tima0();
        step(2'd1, 1'b0, 8'h00);
        step(2'd1, 1'b0, 8'h00);
        step(2'd1, 1'b1, 8'h11);
        irqc = 0;
        for (int i = 0; i < 8; i++) begin
            step(2'd1, 1'b0, 8'h00);
            if (i == 0) chk("reload_tima_wr_ign", 32'(last_rd), 32'h40);
            if (last_irq) irqc++;
        end
        chk("reload_irq_a", 32'(irqc), 32'd4);

        // TMA write in the RELOAD cycle lands in TIMA.
        step(2'd1, 1'b1, 8'hfe);
        wait_tima0();
        step(2'd1, 1'b0, 8'h00);
        step(2'd1, 1'b0, 8'h00);
        step(2'd2, 1'b1, 8'h99);
        step(2'd1, 1'b0, 8'h00);
        chk("reload_tma_wr", 32'(last_rd), 32'h99);
        chk("reload_irq_b", 32'(last_irq), 32'd1);
        step(2'd2, 1'b0, 8'h00);
        chk("reload_tma_val", 32'(last_rd), 32'h99);

        // DIV write while div[3]=1 produces one TIMA increment.
        for (int i = 0; i < 32 && (m_div & 15) != 9; i++) step(2'd0, 1'b0, 8'h00);
        step(2'd1, 1'b1, 8'h20);
        step(2'd1, 1'b0, 8'h00);
        step(2'd0, 1'b1, 8'h00);
        step(2'd1, 1'b0, 8'h00);
        chk("divwr_before", 32'(last_rd), 32'h20);
        step(2'd1, 1'b0, 8'h00);
        chk("divwr_inc", 32'(last_rd), 32'h21);
        step(2'd0, 1'b0, 8'h00);
        chk("div_after_clr", 32'(last_rd), 32'h00);
        repeat (252) step(2'd0, 1'b0, 8'h00);
        step(2'd0, 1'b0, 8'h00);
        chk("div_255", 32'(last_rd), 32'h00);
        step(2'd0, 1'b0, 8'h00);
        chk("div_256", 32'(last_rd), 32'h01);

        // Slowest rate, disable hold, and divider wrap.
        step(2'd3, 1'b1, 8'h00);
        step(2'd0, 1'b1, 8'h00);
        step(2'd3, 1'b1, 8'h04);
        step(2'd1, 1'b1, 8'h00);
        repeat (1023) step(2'd1, 1'b0, 8'h00);
        chk("rate1024_pre", 32'(last_rd), 32'h00);
        step(2'd1, 1'b0, 8'h00);
        chk("rate1024", 32'(last_rd), 32'h01);
        step(2'd3, 1'b1, 8'h00);
        repeat (4096) step(2'd1, 1'b0, 8'h00);
        chk("tac_off_hold", 32'(last_rd), 32'h01);
        step(2'd0, 1'b1, 8'h00);
        repeat (65535) step(2'd0, 1'b0, 8'h00);
        step(2'd0, 1'b0, 8'h00);
        chk("div_ffff", 32'(last_rd), 32'hff);
        step(2'd0, 1'b0, 8'h00);
        chk("div_wrap", 32'(last_rd), 32'h00);

        // Reset two cycles into OVF aborts the reload.
        step(2'd3, 1'b1, 8'h05);
        step(2'd2, 1'b1, 8'h40);
        step(2'd1, 1'b1, 8'hff);
        wait_tima0();
        step(2'd1, 1'b0, 8'h00);
        rst = 1'b0;
        reg_write = 1'b0;
        m_reset();
        for (int a = 0; a < 4; a++) begin
            reg_addr = 2'(a);
            #1;
            chk("rst_rd", 32'(reg_d_rd), (a == 3) ? 32'hf8 : 32'h00);
        end
        chk("rst_irq", 32'(irq_timer), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        irqc = 0;
        for (int i = 0; i < 20; i++) begin
            step(2'd1, 1'b0, 8'h00);
            if (last_irq) irqc++;
        end
        chk("rst_no_irq", 32'(irqc), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            ra = 2'($urandom_range(0, 3));
            rw = ($urandom_range(0, 15) < 2) ? 1'b1 : 1'b0;
            rdat = 8'($urandom_range(0, 255));
            if (rw && ra == 2'd0 && $urandom_range(0, 3) != 0) rw = 1'b0;
            if (rw && ra == 2'd1 && $urandom_range(0, 1) == 1) rdat = 8'($urandom_range(252, 255));
            if (rw && ra == 2'd3 && $urandom_range(0, 3) != 0) rdat = 8'($urandom_range(4, 7));
            step(ra, rw, rdat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
